// File: rtl/border_feed_ctrl.sv
// Border-register feed sequencer for one systolic-array edge: clears, feeds and skews row enables.
// Optional stall counter output perf_stall_cnt is built when BORDER_FEED_PERF_EN is defined.
module border_feed_ctrl #(
  parameter int unsigned ROWS = 16,
  parameter int unsigned KW   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [KW-1:0]   cmd_len,
  input  logic            cmd_clr,
  input  logic            src_valid,
  output logic            src_ready,
  output logic [ROWS-1:0] border_en,
  output logic [ROWS-1:0] border_clr,
  output logic            busy,
  output logic            done
`ifdef BORDER_FEED_PERF_EN
  ,
  output logic [15:0]     perf_stall_cnt
`endif
);

  localparam int unsigned DW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [DW-1:0] DrainLoad = DW'(ROWS - 1);

  typedef enum logic [1:0] {StIdle, StClear, StFeed, StDrain} state_e;

  state_e        state_q;
  logic [KW-1:0] rem_q;
  logic [DW-1:0] drain_q;
  logic          done_q;
  logic          accept;
  logic          beat;

  assign accept = cmd_valid && (state_q == StIdle);
  assign beat   = src_valid && src_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      rem_q   <= '0;
      drain_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            rem_q <= cmd_len;
            if (cmd_clr) begin
              state_q <= StClear;
            end else if (cmd_len != '0) begin
              state_q <= StFeed;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        StClear: begin
          if (rem_q != '0) begin
            state_q <= StFeed;
          end else begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end
        end
        StFeed: begin
          if (beat) begin
            rem_q <= rem_q - 1'b1;
            if (rem_q == KW'(1)) begin
              // A single-row column has no skew to drain.
              if (ROWS > 1) begin
                state_q <= StDrain;
                drain_q <= DrainLoad;
              end else begin
                state_q <= StIdle;
                done_q  <= 1'b1;
              end
            end
          end
        end
        StDrain: begin
          if (drain_q <= DW'(1)) begin
            state_q <= StIdle;
            drain_q <= '0;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs are forced to their idle values while rst is held.
  assign cmd_ready  = rst || (state_q == StIdle);
  assign src_ready  = !rst && (state_q == StFeed) && (rem_q != '0);
  assign busy       = !rst && (state_q != StIdle);
  assign done       = !rst && done_q;
  assign border_clr = (!rst && (state_q == StClear)) ? '1 : '0;
  assign border_en[0] = beat;

  if (ROWS > 1) begin : g_chain
    logic [ROWS-2:0] sh_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        sh_q <= '0;
      end else begin
        sh_q[0] <= beat;
        for (int i = 1; i < int'(ROWS) - 1; i++) begin
          sh_q[i] <= sh_q[i-1];
        end
      end
    end

    assign border_en[ROWS-1:1] = rst ? '0 : sh_q;
  end

`ifdef BORDER_FEED_PERF_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (accept) begin
      stall_q <= '0;
    end else if (src_ready && !src_valid && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign perf_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_border_feed_ctrl.sv
// Bench for border_feed_ctrl: directed vector table, reset and ROWS=1 sequences, random vs model.
module tb_border_feed_ctrl;
  localparam int R  = 4;
  localparam int KW = 8;
  localparam int BIG = 1 << 30;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, cmd_valid, cmd_clr, src_valid;
  logic [KW-1:0] cmd_len;
  logic          cmd_ready, src_ready, busy, done;
  logic [R-1:0]  border_en, border_clr;
  logic [15:0]   perf_stall_cnt;

  logic          q_cv, q_clr, q_sv;
  logic [KW-1:0] q_len;
  logic          q_cr, q_sr, q_busy, q_done;
  logic [0:0]    q_en, q_bclr;
  logic [15:0]   q_perf;

  int total = 0;
  int bad = 0;

  border_feed_ctrl #(.ROWS(R), .KW(KW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .cmd_clr(cmd_clr), .src_valid(src_valid), .src_ready(src_ready), .border_en(border_en),
    .border_clr(border_clr), .busy(busy), .done(done)
`ifdef BORDER_FEED_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  border_feed_ctrl #(.ROWS(1), .KW(KW)) dut1 (
    .clk(clk), .rst(rst), .cmd_valid(q_cv), .cmd_ready(q_cr), .cmd_len(q_len),
    .cmd_clr(q_clr), .src_valid(q_sv), .src_ready(q_sr), .border_en(q_en),
    .border_clr(q_bclr), .busy(q_busy), .done(q_done)
`ifdef BORDER_FEED_PERF_EN
    , .perf_stall_cnt(q_perf)
`endif
  );

`ifndef BORDER_FEED_PERF_EN
  assign perf_stall_cnt = '0;
  assign q_perf = '0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       cv;
    logic [7:0] len;
    logic       clr;
    logic       sv;
    logic       cr, sr, bsy, dn;
    logic [3:0] en, bclr;
    logic [15:0] perf;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic cv, logic [7:0] len, logic clr, logic sv, logic cr, logic sr,
                              logic bsy, logic dn, logic [3:0] en, logic [3:0] bclr,
                              logic [15:0] perf);
    vec_t v;
    v.cv = cv; v.len = len; v.clr = clr; v.sv = sv;
    v.cr = cr; v.sr = sr; v.bsy = bsy; v.dn = dn;
    v.en = en; v.bclr = bclr; v.perf = perf;
    vecs.push_back(v);
  endfunction

  // Reference model state for the random phase: per-tile schedule in absolute cycles.
  bit acc_log[0:1023];
  int last_rst, has_tile, start_c, feed_c, t_clr, t_done, rem, perf_m;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic e_cr, e_sr, e_busy, e_done, e_acc, in_tile;
    logic [3:0] e_en, e_clr;

    // Test plan case 1: len 3, no clear, src_valid always high.
    add(1, 3, 0, 1, 1, 0, 0, 0, 4'b0000, 4'h0, 0);
    add(0, 0, 0, 1, 0, 1, 1, 0, 4'b0001, 4'h0, 0);
    add(0, 0, 0, 1, 0, 1, 1, 0, 4'b0011, 4'h0, 0);
    add(0, 0, 0, 1, 0, 1, 1, 0, 4'b0111, 4'h0, 0);
    add(0, 0, 0, 1, 0, 0, 1, 0, 4'b1110, 4'h0, 0);
    add(0, 0, 0, 1, 0, 0, 1, 0, 4'b1100, 4'h0, 0);
    add(0, 0, 0, 1, 0, 0, 1, 0, 4'b1000, 4'h0, 0);
    add(0, 0, 0, 1, 1, 0, 0, 1, 4'b0000, 4'h0, 0);
    // Case 2: len 2 with clear.
    add(1, 2, 1, 1, 1, 0, 0, 0, 4'b0000, 4'h0, 0);
    add(0, 0, 0, 1, 0, 0, 1, 0, 4'b0000, 4'hF, 0);
    add(0, 0, 0, 1, 0, 1, 1, 0, 4'b0001, 4'h0, 0);
    add(0, 0, 0, 1, 0, 1, 1, 0, 4'b0011, 4'h0, 0);
    add(0, 0, 0, 1, 0, 0, 1, 0, 4'b0110, 4'h0, 0);
    add(0, 0, 0, 1, 0, 0, 1, 0, 4'b1100, 4'h0, 0);
    add(0, 0, 0, 1, 0, 0, 1, 0, 4'b1000, 4'h0, 0);
    add(0, 0, 0, 1, 1, 0, 0, 1, 4'b0000, 4'h0, 0);
    // Case 3: len 3 with a bubble in the second feed slot.
    add(1, 3, 0, 1, 1, 0, 0, 0, 4'b0000, 4'h0, 0);
    add(0, 0, 0, 1, 0, 1, 1, 0, 4'b0001, 4'h0, 0);
    add(0, 0, 0, 0, 0, 1, 1, 0, 4'b0010, 4'h0, 0);
    add(0, 0, 0, 1, 0, 1, 1, 0, 4'b0101, 4'h0, 1);
    add(0, 0, 0, 1, 0, 1, 1, 0, 4'b1011, 4'h0, 1);
    add(0, 0, 0, 1, 0, 0, 1, 0, 4'b0110, 4'h0, 1);
    add(0, 0, 0, 1, 0, 0, 1, 0, 4'b1100, 4'h0, 1);
    add(0, 0, 0, 1, 0, 0, 1, 0, 4'b1000, 4'h0, 1);
    add(0, 0, 0, 1, 1, 0, 0, 1, 4'b0000, 4'h0, 1);
    // Case 4: zero-length tile completes without ever going busy.
    add(1, 0, 0, 1, 1, 0, 0, 0, 4'b0000, 4'h0, 1);
    add(0, 0, 0, 1, 1, 0, 0, 1, 4'b0000, 4'h0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 4'h0, 0);

    rst = 1'b1; cmd_valid = 1'b0; cmd_len = '0; cmd_clr = 1'b0; src_valid = 1'b0;
    q_cv = 1'b0; q_len = '0; q_clr = 1'b0; q_sv = 1'b0;
    next_cycle();
    #4;
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_outs", {src_ready, busy, done}, 0);
    chk("reset_en_clr", {border_en, border_clr}, 0);
    next_cycle();
    rst = 1'b0;

    foreach (vecs[k]) begin
      cmd_valid = vecs[k].cv; cmd_len = vecs[k].len; cmd_clr = vecs[k].clr;
      src_valid = vecs[k].sv;
      #4;
      chk($sformatf("tbl%0d_en", k), border_en, vecs[k].en);
      chk($sformatf("tbl%0d_clr", k), border_clr, vecs[k].bclr);
      chk($sformatf("tbl%0d_ctl", k), {cmd_ready, src_ready, busy, done},
          {vecs[k].cr, vecs[k].sr, vecs[k].bsy, vecs[k].dn});
`ifdef BORDER_FEED_PERF_EN
      chk($sformatf("tbl%0d_perf", k), perf_stall_cnt, vecs[k].perf);
`endif
      next_cycle();
    end

    // Reset in the middle of a len 5 tile.
    cmd_valid = 1'b1; cmd_len = 5; cmd_clr = 1'b0; src_valid = 1'b1;
    next_cycle();
    cmd_valid = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b1;
    #4;
    chk("midrst_cmd_ready", cmd_ready, 1);
    chk("midrst_en", border_en, 0);
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #4;
      chk("postrst_en", border_en, 0);
      chk("postrst_ctl", {cmd_ready, src_ready, busy, done}, 4'b1000);
      next_cycle();
    end
    cmd_valid = 1'b1; cmd_len = 1;
    #4;
    chk("postrst_accept", cmd_ready, 1);
    next_cycle();
    cmd_valid = 1'b0;
    lat = 1;
    while (lat <= 20) begin
      #4;
      if (done) break;
      next_cycle();
      lat++;
    end
    chk("postrst_done_latency", lat, R + 1);
    next_cycle();

    // ROWS=1: no drain, back-to-back command in the done cycle.
    q_cv = 1'b1; q_len = 2; q_sv = 1'b1;
    #4;
    chk("r1_c0_ready", q_cr, 1);
    next_cycle();
    q_cv = 1'b0;
    #4;
    chk("r1_c1", {q_en, q_sr, q_busy, q_done}, 4'b1110);
    next_cycle();
    #4;
    chk("r1_c2", {q_en, q_sr, q_busy, q_done}, 4'b1110);
    next_cycle();
    q_cv = 1'b1; q_len = 1;
    #4;
    chk("r1_c3_done", {q_cr, q_en, q_busy, q_done}, 4'b1001);
    next_cycle();
    q_cv = 1'b0;
    #4;
    chk("r1_c4_second", {q_en, q_sr, q_busy, q_done}, 4'b1110);
    next_cycle();
    #4;
    chk("r1_c5_done", {q_cr, q_busy, q_done}, 3'b101);
    next_cycle();
    q_sv = 1'b0;

    // Random traffic against the schedule model.
    has_tile = 0; last_rst = -1; perf_m = 0; rem = 0;
    start_c = 0; feed_c = 0; t_clr = -1; t_done = BIG;
    for (int t = 0; t < 600; t++) begin
      rst = (t == 0) || ($urandom_range(0, 99) == 0);
      src_valid = ($urandom_range(0, 3) != 0);
      cmd_valid = ($urandom_range(0, 2) == 0);
      cmd_len = KW'($urandom_range(0, 6));
      cmd_clr = ($urandom_range(0, 1) == 1);
      if (rst) begin
        e_cr = 1'b1; e_sr = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_clr = '0;
      end else begin
        in_tile = (has_tile != 0) && (t >= start_c);
        e_done  = (has_tile != 0) && (t == t_done);
        e_busy  = in_tile && (t < t_done);
        e_cr    = !e_busy;
        e_sr    = in_tile && (t >= feed_c) && (rem > 0);
        e_clr   = (in_tile && (t == t_clr)) ? 4'hF : 4'h0;
      end
      e_acc = src_valid && e_sr;
      acc_log[t] = e_acc;
      e_en = '0;
      if (!rst) begin
        for (int i = 0; i < R; i++) begin
          if ((t - i >= 0) && (t - i > last_rst)) e_en[i] = acc_log[t-i];
        end
      end
      #4;
      chk("rnd_en", border_en, e_en);
      chk("rnd_clr", border_clr, e_clr);
      chk("rnd_ctl", {cmd_ready, src_ready, busy, done}, {e_cr, e_sr, e_busy, e_done});
`ifdef BORDER_FEED_PERF_EN
      chk("rnd_perf", perf_stall_cnt, perf_m);
`endif
      if (rst) begin
        has_tile = 0; last_rst = t; perf_m = 0;
      end else begin
        if (e_sr && !src_valid && perf_m < 65535) perf_m++;
        if (e_acc) begin
          rem--;
          if (rem == 0) t_done = t + R;
        end
        if ((has_tile != 0) && (t >= t_done)) has_tile = 0;
        if (cmd_valid && e_cr) begin
          has_tile = 1;
          start_c  = t + 1;
          feed_c   = t + 1 + int'(cmd_clr);
          t_clr    = cmd_clr ? t + 1 : -1;
          rem      = int'(cmd_len);
          t_done   = (cmd_len == 0) ? t + 1 + int'(cmd_clr) : BIG;
          perf_m   = 0;
        end
      end
      next_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
